// File: rtl/bicubic_line_reorder_4.sv
// Line reorder buffer behind the 4x bicubic upsampler: column-major beats in, raster-order rows out.
// Optional end-of-frame flag on out_eof is enabled with macro BCCI_REORDER_EOF_EN.
module bicubic_line_reorder_4 #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int IMG_WIDTH     = 960,
    parameter int IMG_HEIGHT    = 540
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bcci_rsp_valid,
    output logic                       bf_rsp_ready,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*CHANNEL_WIDTH-1:0] out_data,
    output logic                       out_sol,
    output logic                       out_eol,
    output logic                       out_eof
);
    localparam int DW    = 4 * CHANNEL_WIDTH;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int AW    = COL_W + 3;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          sol;
        logic          eol;
        logic          eof;
        logic          last;
    } entry_t;

    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic [DW-1:0]    rd_data_q;

    logic [1:0]       beat_q, beat_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             wbank_q, wbank_d;
    logic [1:0]       full_q, full_d;

    state_t           state_q, state_d;
    logic             rbank_q, rbank_d;
    logic [1:0]       row_q, row_d;
    logic [COL_W-1:0] rcol_q, rcol_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_sol_q, rd_sol_d, rd_eol_q, rd_eol_d;
    logic             rd_eof_q, rd_eof_d, rd_last_q, rd_last_d;

    entry_t           skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0]       skid_cnt_q, skid_cnt_d;

    logic             accept, issue, pop, push, space, last_addr, drain_done;
    logic [2:0]       occ;
    entry_t           new_entry;

`ifdef BCCI_REORDER_EOF_EN
    localparam int LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    logic [LINE_W-1:0] line_q, line_d;
`endif

    // Write side: beat/col counters, bank-full flags and bank release from the read side.
    always_comb begin
        bf_rsp_ready = !full_q[wbank_q];
        accept       = bcci_rsp_valid & bf_rsp_ready;
        beat_d       = beat_q;
        col_d        = col_q;
        wbank_d      = wbank_q;
        full_d       = full_q;
        if (accept) begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
                if (col_q == COL_LAST) begin
                    col_d          = '0;
                    full_d[wbank_q] = 1'b1;
                    wbank_d        = ~wbank_q;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
        // The bank being drained is never the bank being filled, so both updates can land together.
        if (drain_done) full_d[rbank_q] = 1'b0;
    end

    // Read side: issue only while the in-flight read plus skid contents leave room for one more word.
    always_comb begin
        out_valid  = (skid_cnt_q != 2'd0);
        pop        = out_valid & out_ready;
        occ        = 3'(skid_cnt_q) + 3'(rd_valid_q);
        space      = (occ < 3'd2) || (occ == 3'd2 && pop);
        last_addr  = (row_q == 2'd3) && (rcol_q == COL_LAST);
        issue      = 1'b0;
        drain_done = 1'b0;
        state_d    = state_q;
        rbank_d    = rbank_q;
        row_d      = row_q;
        rcol_d     = rcol_q;
`ifdef BCCI_REORDER_EOF_EN
        line_d     = line_q;
`endif
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q] && space) begin
                    issue   = 1'b1;
                    state_d = READ;
                end
            end
            READ: issue = space;
            DRAIN: begin
                if (pop && skid0_q.last) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                    rbank_d    = ~rbank_q;
`ifdef BCCI_REORDER_EOF_EN
                    line_d     = (line_q == LINE_W'(IMG_HEIGHT - 1)) ? '0 : line_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            if (last_addr) begin
                state_d = DRAIN;
                row_d   = '0;
                rcol_d  = '0;
            end else if (rcol_q == COL_LAST) begin
                rcol_d = '0;
                row_d  = row_q + 2'd1;
            end else begin
                rcol_d = rcol_q + 1'b1;
            end
        end
        rd_valid_d = issue;
        rd_sol_d   = (rcol_q == '0);
        rd_eol_d   = (rcol_q == COL_LAST);
        rd_last_d  = last_addr;
`ifdef BCCI_REORDER_EOF_EN
        rd_eof_d   = last_addr && (line_q == LINE_W'(IMG_HEIGHT - 1));
`else
        rd_eof_d   = 1'b0;
`endif
    end

    // Two-entry skid buffer; entry 0 is always the word presented on the output.
    always_comb begin
        push       = rd_valid_q;
        new_entry  = '{data: rd_data_q, sol: rd_sol_q, eol: rd_eol_q, eof: rd_eof_q, last: rd_last_q};
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid0_d = new_entry;
                else                    skid1_d = new_entry;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = new_entry;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = new_entry;
                end
            end
            default: ;
        endcase
        out_data = skid0_q.data;
        out_sol  = out_valid & skid0_q.sol;
        out_eol  = out_valid & skid0_q.eol;
        out_eof  = out_valid & skid0_q.eof;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wbank_q, beat_q, col_q}] <= {bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1};
        if (issue)  rd_data_q <= mem[{rbank_q, row_q, rcol_q}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= '0;
            col_q      <= '0;
            wbank_q    <= 1'b0;
            full_q     <= '0;
            state_q    <= IDLE;
            rbank_q    <= 1'b0;
            row_q      <= '0;
            rcol_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_sol_q   <= 1'b0;
            rd_eol_q   <= 1'b0;
            rd_eof_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_cnt_q <= '0;
`ifdef BCCI_REORDER_EOF_EN
            line_q     <= '0;
`endif
        end else begin
            beat_q     <= beat_d;
            col_q      <= col_d;
            wbank_q    <= wbank_d;
            full_q     <= full_d;
            state_q    <= state_d;
            rbank_q    <= rbank_d;
            row_q      <= row_d;
            rcol_q     <= rcol_d;
            rd_valid_q <= rd_valid_d;
            rd_sol_q   <= rd_sol_d;
            rd_eol_q   <= rd_eol_d;
            rd_eof_q   <= rd_eof_d;
            rd_last_q  <= rd_last_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            skid_cnt_q <= skid_cnt_d;
`ifdef BCCI_REORDER_EOF_EN
            line_q     <= line_d;
`endif
        end
    end
endmodule

// File: tb/tb_bicubic_line_reorder_4.sv
// Directed bench for bicubic_line_reorder_4 at IMG_WIDTH=4, IMG_HEIGHT=2; expected words come from a queue of hand-built lines.
module tb_bicubic_line_reorder_4;
    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bcci_rsp_valid;
    logic        bf_rsp_ready;
    logic [7:0]  d1, d2, d3, d4;
    logic        out_valid, out_ready, out_sol, out_eol, out_eof;
    logic [31:0] out_data;

    bicubic_line_reorder_4 #(.CHANNEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
        .bcci_rsp_data1(d1), .bcci_rsp_data2(d2), .bcci_rsp_data3(d3), .bcci_rsp_data4(d4),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sol;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rx_data[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          line_no  = 0;
    bit          stop_rand = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Beat (c,k) of line tag carries four consecutive byte values starting at tag*37 + c*16 + k*4.
    function automatic logic [31:0] beat_word(input int tag, input int c, input int k);
        logic [7:0] b;
        b = 8'(tag * 37 + c * 16 + k * 4);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", out_data, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check_val("word_data", out_data, e.data);
                check_val("word_sol", 32'(out_sol), 32'(e.sol));
                check_val("word_eol", 32'(out_eol), 32'(e.eol));
                check_val("word_eof", 32'(out_eof), 32'(e.eof));
                rx_data.push_back(out_data);
            end
        end
    end

    task automatic push_line_exp(input int tag);
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                e.data = beat_word(tag, c, r);
                e.sol  = (c == 0);
                e.eol  = (c == W - 1);
`ifdef BCCI_REORDER_EOF_EN
                e.eof  = (r == 3) && (c == W - 1) && ((line_no % H) == H - 1);
`else
                e.eof  = 1'b0;
`endif
                exp_q.push_back(e);
            end
        end
        line_no++;
    endtask

    task automatic send_beat(input logic [31:0] w);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bcci_rsp_valid = 1'b1;
        {d4, d3, d2, d1} = w;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = bf_rsp_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bcci_rsp_valid = 1'b0;
        if (!acc) check_val("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_line(input int tag, input int gap_max);
        for (int c = 0; c < W; c++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
                send_beat(beat_word(tag, c, k));
            end
        end
        push_line_exp(tag);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic measure_latency(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, n, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        bcci_rsp_valid = 1'b0;
        {d4, d3, d2, d1} = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready", 32'(bf_rsp_ready), 32'd1);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_sol", 32'(out_sol), 32'd0);
        check_val("rst_eol", 32'(out_eol), 32'd0);
        check_val("rst_eof", 32'(out_eof), 32'd0);
        @(posedge clk);
        #1;

        // Single line, spec pattern, free-flowing output.
        send_line(0, 0);
        measure_latency("first_valid_latency");
        wait_drain();
        check_val("line0_words", rx_data.size(), 16);
        check_val("line0_word0", rx_data[0], 32'h03020100);
        check_val("line0_word1", rx_data[1], 32'h13121110);
        check_val("line0_word4", rx_data[4], 32'h07060504);
        check_val("line0_word15", rx_data[15], 32'h3f3e3d3c);

        // Two lines against a stalled output: both banks fill, upstream blocks.
        out_ready = 1'b0;
        send_line(1, 0);
        send_line(2, 0);
        @(negedge clk);
        check_val("ready_both_full", 32'(bf_rsp_ready), 32'd0);
        check_val("stall_valid", 32'(out_valid), 32'd1);
        held = out_data;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("stall_hold_data", out_data, held);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check_val("bp_words", rx_data.size(), 48);

        // Final accept of one bank lands on the same edge as the drain exit of the other.
        out_ready = 1'b0;
        send_line(3, 0);
        for (int i = 0; i < 15; i++) send_beat(beat_word(4, i / 4, i % 4));
        out_ready = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        bcci_rsp_valid = 1'b1;
        {d4, d3, d2, d1} = beat_word(4, 3, 3);
        @(negedge clk);
        check_val("swap_last_ready", 32'(bf_rsp_ready), 32'd1);
        @(posedge clk);
        #1;
        bcci_rsp_valid = 1'b0;
        check_val("swap_prev_done", exp_q.size(), 0);
        push_line_exp(4);
        @(negedge clk);
        check_val("swap_ready_after", 32'(bf_rsp_ready), 32'd1);
        check_val("swap_valid_gap", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("swap_valid_next", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("swap_restart", 32'(out_valid), 32'd1);
        wait_drain();
        check_val("swap_words", rx_data.size(), 80);

        // Ten lines with random upstream gaps and random output backpressure.
        fork
            begin
                while (1) begin
                    @(posedge clk);
                    #1;
                    if (stop_rand) break;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 10; i++) send_line(10 + i, 2);
        stop_rand = 1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check_val("rand_words", rx_data.size(), 240);

        // Reset six beats into a line; only the following clean line may appear.
        for (int i = 0; i < 6; i++) send_beat(beat_word(99, i / 4, i % 4));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        line_no = 0;
        @(negedge clk);
        check_val("midrst_ready", 32'(bf_rsp_ready), 32'd1);
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_line(5, 1);
        measure_latency("post_rst_latency");
        wait_drain();
        check_val("total_words", rx_data.size(), 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
